bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
- Produces the packed BCD digit bus that feeds the per-digit seven-segment decoders.
- Start/done handshake. The result is held stable between conversions so the display path sees a steady value.
- Out-of-range inputs produce all-blank digit codes, which the segment decoders render as dark.

Parameters:
BIN_W, 14, width of the binary input; legal range 4..20
DIGITS, 4, number of BCD output digits; legal range 1..6

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a conversion; sampled only while idle
bin  input  BIN_W  unsigned binary value; captured on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd and overflow valid and updated
bcd  output  4*DIGITS  packed digits; nibble 0 = units, nibble DIGITS-1 = most significant
overflow  output  1  last conversion input exceeded 10^DIGITS-1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal registers cleared.
- FSM states: IDLE and CONV.
- IDLE -> CONV: taken on a clk edge when start=1.
  - Capture bin into a shift register and clear the BCD accumulator.
  - Load bit counter with BIN_W.
  - Latch ovf_pending = (bin > 10^DIGITS-1).
  - busy=1 from this edge.
- CONV, each edge:
  - Every accumulator nibble >=5 gets +3.
  - Then {acc, shreg} shifts left by 1; the MSB of shreg enters acc bit 0.
  - Counter decrements.
- CONV -> IDLE: on the edge where the counter reaches 1, i.e. the final (BIN_W-th) shift.
  - bcd <= post-shift accumulator, or all nibbles 4'hF if ovf_pending.
  - overflow <= ovf_pending.
  - done <= 1 for exactly one cycle.
  - busy <= 0.
- Latency: start accepted at edge k -> done high in the cycle after edge k+BIN_W. Throughput is one conversion per BIN_W+1 cycles when restarting in the done cycle.
- start while busy=1: ignored. No queueing; bin is not re-sampled.
- start high in the done cycle: accepted, since the FSM is already IDLE. bcd and overflow keep the just-completed result until the next done.
- start held high continuously: back-to-back conversions, each re-sampling bin.
- bcd and overflow change only on a done edge or on reset. Their values are stable at all other times.
- Reset asserted mid-conversion: conversion aborted immediately, no done pulse, outputs return to reset values.
- Accumulator width 4*DIGITS. When overflow occurs its content may be garbage; it is discarded and never exposed.
- bin=0: result all-zero digits (not blank). Leading-zero suppression is not this block's job.

Decomposition:
- Package bin2bcd_pkg:
  - State enum type (IDLE, CONV).
  - Constant BCD_BLANK = 4'hF.
  - Constant function pow10(n) used for the overflow threshold.
  - Constant function clog2-based counter width for BIN_W.
- Sub-module bcd_add3: 4-bit in / 4-bit out, combinational, +3 when input >=5. Instantiated DIGITS times via generate.

Test Plan:
- Conversion latency: reset, start=1 for one cycle with bin=1234 -> busy high 14 cycles, done pulse 14 cycles after start edge, bcd=16'h1234, overflow=0.
- Boundary values:
  - bin=0 -> bcd=16'h0000, overflow=0.
  - bin=9999 -> bcd=16'h9999, overflow=0.
  - bin=10000 -> bcd=16'hFFFF, overflow=1.
  - bin=16383 -> bcd=16'hFFFF, overflow=1.
- Start while busy: start=1 at cycle 5 of a conversion of 42 with bin=777 -> ignored; done once with bcd=16'h0042. No second done without a new start.
- Back-to-back: start held high, bin=5 then 8191 changed mid-run -> first done bcd=16'h0005. Second conversion accepted in the done cycle gives bcd=16'h8191 after 14 more cycles. bcd stable in between.
- Async reset: rst_n low at cycle 7 of a conversion of 4321 -> busy, done, bcd, overflow all 0 within the same cycle, no done pulse. A fresh start after release converts correctly.
- Parameter sweep: BIN_W=7, DIGITS=2, exhaustive 0..127 against a reference model; values >99 give 8'hFF and overflow=1.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, the blank digit code and elaboration-time math.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Digit code the seven-segment decoders render as a dark digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Counter must hold the value bin_w itself, not just bin_w-1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit correction stage of double dabble: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, start/done handshake,
// result held stable between conversions; out-of-range inputs yield all-blank digits.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CW    = cnt_width(BIN_W);
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  state_t            state, state_n;
  logic [BIN_W-1:0]  shreg, shreg_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_shift;
  logic [CW-1:0]     cnt, cnt_n;
  logic              ovf_pend, ovf_pend_n;
  logic [ACC_W-1:0]  bcd_n;
  logic              overflow_n;
  logic              done_n;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Corrected accumulator shifted left, taking the next binary bit MSB-first.
  assign acc_shift = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};

  assign busy = (state == CONV);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    acc_n      = acc;
    cnt_n      = cnt;
    ovf_pend_n = ovf_pend;
    bcd_n      = bcd;
    overflow_n = overflow;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = CONV;
          shreg_n    = bin;
          acc_n      = '0;
          cnt_n      = CW'(BIN_W);
          ovf_pend_n = (64'(bin) > MAX_VAL);
        end
      end
      CONV: begin
        acc_n   = acc_shift;
        shreg_n = {shreg[BIN_W-2:0], 1'b0};
        cnt_n   = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n    = IDLE;
          done_n     = 1'b1;
          overflow_n = ovf_pend;
          // Accumulator may hold garbage on overflow; never expose it.
          bcd_n      = ovf_pend ? {DIGITS{BCD_BLANK}} : acc_shift;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      ovf_pend <= ovf_pend_n;
      bcd      <= bcd_n;
      overflow <= overflow_n;
      done     <= done_n;
    end
  end

endmodule
